multicycle_control_fsm: RTL and testbench

//  Moore-style control FSM that sequences the shared MIPS datapath (PC, unified memory, IR, register file, ALU)

---
 rtl/multicycle_control_fsm_pkg.sv | 76 +++++++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, state codes, control-word fields.
package multicycle_control_fsm_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned TIMER_W  = 8;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_RD    = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WR    = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_INT_SAVE  = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_VECTOR = 2'b11
  } pc_src_e;

  // Per-state datapath control word
  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_source;
    logic    epc_write;
    logic    int_ack;
  } ctrl_t;

  // States that wait on mem_ready and are covered by the bus timeout
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait-state counter; flags a bus timeout after TIMEOUT_CYCLES unready cycles.
module multicycle_control_fsm_mem_wait_timer
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Count unready cycles; any completion, timeout or non-wait state restarts from zero
  always_comb begin
    timeout = waiting && !mem_ready && (count_q == LIMIT);
    count_d = '0;
    if (waiting && !mem_ready && !timeout) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM sequencing the shared multicycle MIPS datapath, with wait states,
// bus timeout abort and interrupt entry.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          INT_ENABLE     = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                interrupt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                epc_write,
  output logic                int_ack,
  output logic                bus_error,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state
);

  state_e state_q;
  state_e state_d;
  logic   pending_q;
  logic   pending_d;
  logic   timeout;
  state_e eoi_state;
  ctrl_t  ctrl;

  // The zero flag gates pc_write_cond inside the datapath; the FSM itself does not branch on it
  logic unused_zero;
  assign unused_zero = zero;

  multicycle_control_fsm_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .waiting  (is_wait_state(state_q)),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // Next-state logic and interrupt-pending tracking
  always_comb begin
    state_d   = state_q;
    eoi_state = pending_q ? ST_INT_SAVE : ST_FETCH;

    pending_d = pending_q;
    if (state_q == ST_INT_SAVE) begin
      pending_d = 1'b0;
    end
    if (INT_ENABLE && interrupt) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_FETCH: begin
        if (timeout) begin
          state_d = eoi_state;
        end else if (mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default:      state_d = eoi_state;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (timeout) begin
          state_d = eoi_state;
        end else if (mem_ready) begin
          state_d = ST_MEM_WB;
        end
      end
      ST_MEM_WB:    state_d = eoi_state;
      ST_MEM_WR: begin
        if (timeout || mem_ready) begin
          state_d = eoi_state;
        end
      end
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = eoi_state;
      ST_BRANCH:    state_d = eoi_state;
      ST_JUMP:      state_d = eoi_state;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = eoi_state;
      ST_INT_SAVE:  state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  // State and pending-interrupt registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Control word decode from current state (FETCH writes also follow mem_ready)
  always_comb begin
    ctrl       = '0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      ST_INT_SAVE: begin
        ctrl.epc_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_VECTOR;
        ctrl.int_ack   = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign epc_write     = ctrl.epc_write;
  assign int_ack       = ctrl.int_ack;
  assign bus_error     = timeout;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM (timeout shortened to 4 cycles).
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic       clock = 1'b0;
  logic       reset, interrupt, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       epc_write, int_ack, bus_error, illegal_op;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .INT_ENABLE(1'b1)) dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .epc_write(epc_write), .int_ack(int_ack), .bus_error(bus_error),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clock = ~clock;

  // Pulse reset for one cycle; returns just after the edge with state in FETCH
  task automatic apply_reset();
    reset = 1'b1; interrupt = 1'b0; zero = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; interrupt = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = OP_J;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL reset_mem_read got %0b exp 1", mem_read); end
    vectors++; if (alu_src_b !== 2'b01) begin miscompares++; $display("FAIL reset_alu_src_b got %0b exp 01", alu_src_b); end
    vectors++; if (ir_write !== 1'b1) begin miscompares++; $display("FAIL reset_ir_write got %0b exp 1", ir_write); end
    vectors++; if (int_ack !== 1'b0) begin miscompares++; $display("FAIL reset_int_ack got %0b exp 0", int_ack); end
    reset = 1'b0;
    @(posedge clock); #1;
    vectors++; if (state !== 4'd1) begin miscompares++; $display("FAIL reset_release_state got %0d exp 1", state); end
    @(posedge clock); #1;
    vectors++; if (state !== 4'd9) begin miscompares++; $display("FAIL reset_jump_state got %0d exp 9", state); end
    vectors++; if (pc_source !== 2'b10) begin miscompares++; $display("FAIL reset_jump_pcsrc got %0b exp 10", pc_source); end
    @(posedge clock); #1;
  endtask

  task automatic test_lw();
    int   st[6] = '{0, 1, 2, 3, 4, 0};
    logic rw[6] = '{0, 0, 0, 0, 1, 0};
    apply_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if (state !== 4'(st[i])) begin miscompares++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, st[i]); end
      vectors++; if (reg_write !== rw[i]) begin miscompares++; $display("FAIL lw_reg_write[%0d] got %0b exp %0b", i, reg_write, rw[i]); end
      if (st[i] == 4) begin
        vectors++; if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin miscompares++; $display("FAIL lw_wb_mux got m2r=%0b dst=%0b exp 1/0", mem_to_reg, reg_dst); end
      end
      if (st[i] == 3) begin
        vectors++; if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin miscompares++; $display("FAIL lw_mem_rd got rd=%0b iord=%0b exp 1/1", mem_read, i_or_d); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int   st[8]  = '{0, 1, 2, 5, 5, 5, 5, 0};
    logic mw[8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
    apply_reset();
    opcode = OP_SW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      vectors++; if (state !== 4'(st[i])) begin miscompares++; $display("FAIL sw_state[%0d] got %0d exp %0d", i, state, st[i]); end
      vectors++; if (mem_write !== mw[i]) begin miscompares++; $display("FAIL sw_mem_write[%0d] got %0b exp %0b", i, mem_write, mw[i]); end
      vectors++; if (bus_error !== 1'b0) begin miscompares++; $display("FAIL sw_bus_error[%0d] got %0b exp 0", i, bus_error); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_timeout();
    logic be[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    apply_reset();
    opcode = OP_LW; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if (bus_error !== be[i]) begin miscompares++; $display("FAIL to_bus_error[%0d] got %0b exp %0b", i, bus_error, be[i]); end
      vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL to_state[%0d] got %0d exp 0", i, state); end
      vectors++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin miscompares++; $display("FAIL to_writes[%0d] got ir=%0b pc=%0b exp 0/0", i, ir_write, pc_write); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_interrupt();
    logic irq[6] = '{0, 0, 1, 0, 0, 0};
    int   st[6]  = '{0, 1, 6, 7, 12, 0};
    logic rw[6]  = '{0, 0, 0, 1, 0, 0};
    logic ack[6] = '{0, 0, 0, 0, 1, 0};
    int   ps[6]  = '{0, 0, 0, 0, 3, 0};
    apply_reset();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      interrupt = irq[i];
      #1;
      vectors++; if (state !== 4'(st[i])) begin miscompares++; $display("FAIL int_state[%0d] got %0d exp %0d", i, state, st[i]); end
      vectors++; if (reg_write !== rw[i]) begin miscompares++; $display("FAIL int_reg_write[%0d] got %0b exp %0b", i, reg_write, rw[i]); end
      vectors++; if (int_ack !== ack[i] || epc_write !== ack[i]) begin miscompares++; $display("FAIL int_ack_epc[%0d] got %0b/%0b exp %0b", i, int_ack, epc_write, ack[i]); end
      vectors++; if (pc_source !== 2'(ps[i])) begin miscompares++; $display("FAIL int_pc_source[%0d] got %0d exp %0d", i, pc_source, ps[i]); end
      if (st[i] == 7) begin
        vectors++; if (reg_dst !== 1'b1) begin miscompares++; $display("FAIL int_r_wb_dst got %0b exp 1", reg_dst); end
      end
      @(posedge clock); #1;
    end
    interrupt = 1'b0;
  endtask

  task automatic test_illegal_beq();
    logic [5:0] opc[7] = '{6'h3F, 6'h3F, 6'h3F, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ};
    int         st[7]  = '{0, 1, 0, 1, 8, 0, 1};
    logic       ill[7] = '{0, 1, 0, 0, 0, 0, 0};
    logic       pwc[7] = '{0, 0, 0, 0, 1, 0, 0};
    apply_reset();
    mem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opcode = opc[i];
      #1;
      vectors++; if (state !== 4'(st[i])) begin miscompares++; $display("FAIL ib_state[%0d] got %0d exp %0d", i, state, st[i]); end
      vectors++; if (illegal_op !== ill[i]) begin miscompares++; $display("FAIL ib_illegal[%0d] got %0b exp %0b", i, illegal_op, ill[i]); end
      vectors++; if (pc_write_cond !== pwc[i]) begin miscompares++; $display("FAIL ib_pwc[%0d] got %0b exp %0b", i, pc_write_cond, pwc[i]); end
      if (st[i] == 8) begin
        vectors++; if (pc_source !== 2'b01 || alu_op !== 2'b01) begin miscompares++; $display("FAIL ib_branch got ps=%0b op=%0b exp 01/01", pc_source, alu_op); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] opc[8] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J, OP_J};
    int         st[8]  = '{0, 1, 10, 11, 0, 1, 9, 0};
    logic       rw[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic       pw[8]  = '{1, 0, 0, 0, 1, 0, 1, 1};
    apply_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opcode = opc[i];
      #1;
      vectors++; if (state !== 4'(st[i])) begin miscompares++; $display("FAIL b2b_state[%0d] got %0d exp %0d", i, state, st[i]); end
      vectors++; if (reg_write !== rw[i]) begin miscompares++; $display("FAIL b2b_reg_write[%0d] got %0b exp %0b", i, reg_write, rw[i]); end
      vectors++; if (pc_write !== pw[i]) begin miscompares++; $display("FAIL b2b_pc_write[%0d] got %0b exp %0b", i, pc_write, pw[i]); end
      if (st[i] == 10) begin
        vectors++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin miscompares++; $display("FAIL b2b_addi_exec got a=%0b b=%0b exp 1/10", alu_src_a, alu_src_b); end
      end
      if (st[i] == 9) begin
        vectors++; if (pc_source !== 2'b10) begin miscompares++; $display("FAIL b2b_jump_pcsrc got %0b exp 10", pc_source); end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_timeout();
    test_interrupt();
    test_illegal_beq();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
